reg_file_wb: RTL

//  Integer register file for the single-cycle RISC-V core; the consumer end of the writeback data path.

---
 rtl/rv_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 43 ++++
 rtl/reg_file_wb.sv | 68 ++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared register-file types and constants for the RISC-V core slice.
// Index helpers live here so x0 handling is identical everywhere.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   word_t;

  // x0 is hardwired: never written, never pending, always reads zero.
  function automatic logic isNonZero(input reg_idx_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: tracks outstanding multi-cycle producers
// and raises Stall when a consumed source operand is still pending.
module rf_scoreboard
  import rv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     Wr_En,
  input  reg_idx_t Rd_Addr,
  input  logic     Issue_En,
  input  reg_idx_t Issue_Rd,
  input  reg_idx_t Rs1_Addr,
  input  logic     Rs1_Use,
  input  logic     Fwd1,
  input  reg_idx_t Rs2_Addr,
  input  logic     Rs2_Use,
  input  logic     Fwd2,
  output logic     Stall
);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pendNext;
  logic            w_busy1;
  logic            w_busy2;

  // Set is applied after clear so a newer producer on the same index stays outstanding.
  always_comb begin
    w_pendNext = r_pend;
    if (Wr_En && isNonZero(Rd_Addr)) w_pendNext[Rd_Addr] = 1'b0;
    if (Issue_En && isNonZero(Issue_Rd)) w_pendNext[Issue_Rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pendNext;
  end

  // A same-cycle forwarded write satisfies the operand, so it is not busy.
  assign w_busy1 = r_pend[Rs1_Addr] & isNonZero(Rs1_Addr) & ~Fwd1;
  assign w_busy2 = r_pend[Rs2_Addr] & isNonZero(Rs2_Addr) & ~Fwd2;
  assign Stall   = (Rs1_Use & w_busy1) | (Rs2_Use & w_busy2);

endmodule

// File: rtl/reg_file_wb.sv
// Integer register file at the writeback end of the core, with pending scoreboard.
// Optional macro WB_BYPASS_EN enables same-cycle write-through forwarding to both read ports.
module reg_file_wb
  import rv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  word_t    WData,
  input  logic     Wr_En,
  input  reg_idx_t Rd_Addr,
  input  logic     Issue_En,
  input  reg_idx_t Issue_Rd,
  input  reg_idx_t Rs1_Addr,
  input  logic     Rs1_Use,
  input  reg_idx_t Rs2_Addr,
  input  logic     Rs2_Use,
  output word_t    Rs1_Data,
  output word_t    Rs2_Data,
  output logic     Stall
);

  word_t r_regs [NREG];
  word_t w_rf1;
  word_t w_rf2;
  logic  w_fwd1;
  logic  w_fwd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (Wr_En && isNonZero(Rd_Addr)) begin
      r_regs[Rd_Addr] <= WData;
    end
  end

  assign w_rf1 = isNonZero(Rs1_Addr) ? r_regs[Rs1_Addr] : '0;
  assign w_rf2 = isNonZero(Rs2_Addr) ? r_regs[Rs2_Addr] : '0;

`ifdef WB_BYPASS_EN
  assign w_fwd1   = Wr_En && isNonZero(Rd_Addr) && (Rd_Addr == Rs1_Addr);
  assign w_fwd2   = Wr_En && isNonZero(Rd_Addr) && (Rd_Addr == Rs2_Addr);
  assign Rs1_Data = w_fwd1 ? WData : w_rf1;
  assign Rs2_Data = w_fwd2 ? WData : w_rf2;
`else
  // Without forwarding the operand stays busy until the committing edge.
  assign w_fwd1   = 1'b0;
  assign w_fwd2   = 1'b0;
  assign Rs1_Data = w_rf1;
  assign Rs2_Data = w_rf2;
`endif

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .Wr_En    (Wr_En),
    .Rd_Addr  (Rd_Addr),
    .Issue_En (Issue_En),
    .Issue_Rd (Issue_Rd),
    .Rs1_Addr (Rs1_Addr),
    .Rs1_Use  (Rs1_Use),
    .Fwd1     (w_fwd1),
    .Rs2_Addr (Rs2_Addr),
    .Rs2_Use  (Rs2_Use),
    .Fwd2     (w_fwd2),
    .Stall    (Stall)
  );

endmodule
